// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button-driven HH:MM time/alarm setter feeding the clock load port
// Optional macro DEBOUNCE_EN inserts a per-button debounce counter ahead of edge detection.
module time_set_ctrl #(
`ifdef DEBOUNCE_EN
  parameter int DEBOUNCE_CYCLES = 4,
`endif
  parameter int TIMEOUT_CYCLES  = 30
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       set_btn_i,
  input  logic       inc_btn_i,
  input  logic       dec_btn_i,
  input  logic       target_i,
  input  logic [1:0] cur_h1_i,
  input  logic [3:0] cur_h2_i,
  input  logic [3:0] cur_m1_i,
  input  logic [3:0] cur_m2_i,
  output logic [1:0] h_o1,
  output logic [3:0] h_o2,
  output logic [3:0] m_o1,
  output logic [3:0] m_o2,
  output logic       load_time_n_o,
  output logic       load_alarm_n_o,
  output logic       editing_o,
  output logic [1:0] field_o
);

  typedef enum logic [1:0] {S_IDLE, S_EDIT_HR, S_EDIT_MIN, S_COMMIT} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        r_state, w_next;
  logic [2:0]    w_btn, r_level, r_prev, w_edge;
  logic          w_set_e, w_inc_e, w_dec_e, w_any_e, w_up, w_dn, w_edit, w_to_hit;
  logic          w_cur_hr_ok, w_cur_min_ok;
  logic          r_target;
  logic [1:0]    r_h1, r_sh_h1;
  logic [3:0]    r_h2, r_m1, r_m2, r_sh_h2, r_sh_m1, r_sh_m2;
  logic [TW-1:0] r_to_cnt;
  logic          r_load_time_n, r_load_alarm_n;

  assign w_btn = {dec_btn_i, inc_btn_i, set_btn_i};

`ifdef DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

  logic [2:0]    r_sample;
  logic [DW-1:0] r_db_cnt [3];

  // Level is accepted once the sampled value has differed from it for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sample <= '0;
      r_level  <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sample <= w_btn;
      for (int i = 0; i < 3; i++) begin
        if (r_sample[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_level[i]  <= r_sample[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_level <= '0;
    else         r_level <= w_btn;
  end
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_prev <= '0;
    else         r_prev <= r_level;
  end

  assign w_edge   = r_level & ~r_prev;
  assign w_set_e  = w_edge[0];
  assign w_inc_e  = w_edge[1];
  assign w_dec_e  = w_edge[2];
  assign w_any_e  = |w_edge;
  assign w_up     = w_inc_e & ~w_dec_e & ~w_set_e;
  assign w_dn     = w_dec_e & ~w_inc_e & ~w_set_e;
  assign w_edit   = (r_state == S_EDIT_HR) || (r_state == S_EDIT_MIN);
  assign w_to_hit = (TIMEOUT_CYCLES != 0) && w_edit && !w_any_e && (r_to_cnt == TO_LAST);

  // Out-of-range clock digits are never copied into the edit registers.
  assign w_cur_hr_ok  = (cur_h2_i <= 4'd9) &&
                        ((cur_h1_i < 2'd2) || ((cur_h1_i == 2'd2) && (cur_h2_i <= 4'd3)));
  assign w_cur_min_ok = (cur_m1_i <= 4'd5) && (cur_m2_i <= 4'd9);

  function automatic logic [5:0] hr_step(input logic [5:0] h, input logic up);
    logic [1:0] t;
    logic [3:0] u;
    t = h[5:4];
    u = h[3:0];
    if (up) begin
      if (t == 2'd2 && u == 4'd3) begin t = 2'd0; u = 4'd0; end
      else if (u == 4'd9)         begin t = t + 2'd1; u = 4'd0; end
      else                        u = u + 4'd1;
    end else begin
      if (t == 2'd0 && u == 4'd0) begin t = 2'd2; u = 4'd3; end
      else if (u == 4'd0)         begin t = t - 2'd1; u = 4'd9; end
      else                        u = u - 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic [7:0] min_step(input logic [7:0] m, input logic up);
    logic [3:0] t;
    logic [3:0] u;
    t = m[7:4];
    u = m[3:0];
    if (up) begin
      if (u == 4'd9) begin
        u = 4'd0;
        t = (t == 4'd5) ? 4'd0 : t + 4'd1;
      end else u = u + 4'd1;
    end else begin
      if (u == 4'd0) begin
        u = 4'd9;
        t = (t == 4'd0) ? 4'd5 : t - 4'd1;
      end else u = u - 4'd1;
    end
    return {t, u};
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    editing_o = 1'b0;
    field_o   = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (w_set_e) w_next = S_EDIT_HR;
      end
      S_EDIT_HR: begin
        editing_o = 1'b1;
        field_o   = 2'd1;
        if (w_set_e)       w_next = S_EDIT_MIN;
        else if (w_to_hit) w_next = S_IDLE;
      end
      S_EDIT_MIN: begin
        editing_o = 1'b1;
        field_o   = 2'd2;
        if (w_set_e)       w_next = S_COMMIT;
        else if (w_to_hit) w_next = S_IDLE;
      end
      S_COMMIT: begin
        editing_o = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_target       <= 1'b0;
      {r_h1, r_h2, r_m1, r_m2}             <= '0;
      {r_sh_h1, r_sh_h2, r_sh_m1, r_sh_m2} <= '0;
      r_to_cnt       <= '0;
      r_load_time_n  <= 1'b1;
      r_load_alarm_n <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_set_e) begin
            r_target <= target_i;
            if (target_i) begin
              {r_h1, r_h2, r_m1, r_m2} <= {r_sh_h1, r_sh_h2, r_sh_m1, r_sh_m2};
            end else begin
              {r_h1, r_h2} <= w_cur_hr_ok  ? {cur_h1_i, cur_h2_i} : 6'd0;
              {r_m1, r_m2} <= w_cur_min_ok ? {cur_m1_i, cur_m2_i} : 8'd0;
            end
          end
        end
        S_EDIT_HR: begin
          if (w_up || w_dn) {r_h1, r_h2} <= hr_step({r_h1, r_h2}, w_up);
        end
        S_EDIT_MIN: begin
          if (w_up || w_dn) {r_m1, r_m2} <= min_step({r_m1, r_m2}, w_up);
        end
        S_COMMIT: begin
          if (r_target) {r_sh_h1, r_sh_h2, r_sh_m1, r_sh_m2} <= {r_h1, r_h2, r_m1, r_m2};
        end
        default: ;
      endcase

      if (!w_edit || w_any_e || w_to_hit || (TIMEOUT_CYCLES == 0)) r_to_cnt <= '0;
      else                                                         r_to_cnt <= r_to_cnt + 1'b1;

      // Strobes are registered from the next state so they are low exactly while in COMMIT.
      r_load_time_n  <= !((w_next == S_COMMIT) && !r_target);
      r_load_alarm_n <= !((w_next == S_COMMIT) &&  r_target);
    end
  end

  assign h_o1           = r_h1;
  assign h_o2           = r_h2;
  assign m_o1           = r_m1;
  assign m_o2           = r_m2;
  assign load_time_n_o  = r_load_time_n;
  assign load_alarm_n_o = r_load_alarm_n;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - self-checking bench for time_set_ctrl (vector table plus corner sequences)
// Follows DEBOUNCE_EN when the bundle is built with it.
module tb_time_set_ctrl;

`ifdef DEBOUNCE_EN
  localparam int DBX = 4;
`else
  localparam int DBX = 0;
`endif
  localparam int HOLD    = DBX + 1;
  localparam int SETTLE  = (DBX == 0) ? 2 : DBX + 3;
  localparam int TIMEOUT = 30;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       set_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0, target = 1'b0;
  logic [1:0] cur_h1 = '0;
  logic [3:0] cur_h2 = '0, cur_m1 = '0, cur_m2 = '0;
  logic [1:0] h_o1;
  logic [3:0] h_o2, m_o1, m_o2;
  logic       load_time_n, load_alarm_n, editing;
  logic [1:0] field;
  logic [13:0] dig;

  int n_total = 0, n_pass = 0;
  int lt_low = 0, la_low = 0, both_low = 0;
  int lt0, la0;
  logic found;

  time_set_ctrl dut (
    .clk_i(clk), .reset_i(reset_i),
    .set_btn_i(set_btn), .inc_btn_i(inc_btn), .dec_btn_i(dec_btn), .target_i(target),
    .cur_h1_i(cur_h1), .cur_h2_i(cur_h2), .cur_m1_i(cur_m1), .cur_m2_i(cur_m2),
    .h_o1(h_o1), .h_o2(h_o2), .m_o1(m_o1), .m_o2(m_o2),
    .load_time_n_o(load_time_n), .load_alarm_n_o(load_alarm_n),
    .editing_o(editing), .field_o(field)
  );

  assign dig = {h_o1, h_o2, m_o1, m_o2};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!load_time_n) lt_low++;
    if (!load_alarm_n) la_low++;
    if (!load_time_n && !load_alarm_n) both_low++;
  end

  typedef struct {
    int ph; int pm; bit fld; bit dn; int eh; int em;
  } vec_t;
  vec_t vt[11];

  function automatic logic [13:0] hm(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    @(posedge clk);
    #2 reset_i = 1'b1;
    #2 reset_i = 1'b0;
    tick();
  endtask

  task automatic set_cur(input int h, input int m);
    cur_h1 = 2'(h / 10);
    cur_h2 = 4'(h % 10);
    cur_m1 = 4'(m / 10);
    cur_m2 = 4'(m % 10);
  endtask

  // mask bits: [0] set, [1] inc, [2] dec
  task automatic press(input logic [2:0] mask);
    {dec_btn, inc_btn, set_btn} = mask;
    repeat (HOLD) tick();
    {dec_btn, inc_btn, set_btn} = 3'b000;
    repeat (SETTLE) tick();
  endtask

  task automatic enter_and_find;
    set_btn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (editing) found = 1'b1;
    end
    set_btn = 1'b0;
    chk("entry_seen", 32'(found), 32'd1);
  endtask

  initial begin
    vt[0]  = '{9, 0, 0, 0, 10, 0};
    vt[1]  = '{19, 0, 0, 0, 20, 0};
    vt[2]  = '{23, 0, 0, 0, 0, 0};
    vt[3]  = '{0, 0, 0, 1, 23, 0};
    vt[4]  = '{20, 15, 0, 1, 19, 15};
    vt[5]  = '{10, 15, 0, 1, 9, 15};
    vt[6]  = '{12, 59, 1, 0, 12, 0};
    vt[7]  = '{12, 0, 1, 1, 12, 59};
    vt[8]  = '{12, 9, 1, 0, 12, 10};
    vt[9]  = '{12, 10, 1, 1, 12, 9};
    vt[10] = '{12, 34, 1, 0, 12, 35};

    repeat (3) tick();
    reset_i = 1'b0;
    tick();
    chk("reset_state", {18'd0, dig}, 32'd0);
    chk("reset_ctrl", {27'd0, load_time_n, load_alarm_n, editing, field}, {27'd0, 5'b11000});

    for (int i = 0; i < 11; i++) begin
      apply_reset();
      set_cur(vt[i].ph, vt[i].pm);
      target = 1'b0;
      press(3'b001);
      if (vt[i].fld) press(3'b001);
      press(vt[i].dn ? 3'b100 : 3'b010);
      chk($sformatf("vec%0d", i), {18'd0, dig}, {18'd0, hm(vt[i].eh, vt[i].em)});
    end

    // Time set 13:45 -> 15:44 with one load_time pulse
    apply_reset();
    set_cur(13, 45);
    target = 1'b0;
    lt0 = lt_low; la0 = la_low;
    press(3'b001);
    chk("edit_hr_field", 32'(field), 32'd1);
    press(3'b010);
    press(3'b010);
    press(3'b001);
    chk("edit_min_field", 32'(field), 32'd2);
    press(3'b100);
    press(3'b001);
    chk("timeset_digits", {18'd0, dig}, {18'd0, hm(15, 44)});
    chk("timeset_lt_pulses", lt_low - lt0, 32'd1);
    chk("timeset_la_pulses", la_low - la0, 32'd0);
    chk("timeset_idle", 32'(editing), 32'd0);

    // Wrap sequence from 23:59
    apply_reset();
    set_cur(23, 59);
    press(3'b001);
    press(3'b010);
    chk("wrap_hr_inc", {18'd0, dig}, {18'd0, hm(0, 59)});
    press(3'b001);
    press(3'b010);
    chk("wrap_min_inc", {18'd0, dig}, {18'd0, hm(0, 0)});
    press(3'b100);
    chk("wrap_min_dec", {18'd0, dig}, {18'd0, hm(0, 59)});

    // Alarm set 06:30, then re-entry preloads from the shadow
    apply_reset();
    set_cur(12, 0);
    target = 1'b1;
    lt0 = lt_low; la0 = la_low;
    press(3'b001);
    chk("alarm_preload_reset", {18'd0, dig}, {18'd0, hm(0, 0)});
    repeat (6) press(3'b010);
    press(3'b001);
    repeat (30) press(3'b010);
    press(3'b001);
    chk("alarm_digits", {18'd0, dig}, {18'd0, hm(6, 30)});
    chk("alarm_la_pulses", la_low - la0, 32'd1);
    chk("alarm_lt_pulses", lt_low - lt0, 32'd0);
    set_cur(21, 17);
    press(3'b001);
    chk("alarm_reentry", {18'd0, dig}, {18'd0, hm(6, 30)});
    target = 1'b0;
    la0 = la_low; lt0 = lt_low;
    press(3'b001);
    press(3'b001);
    chk("target_latched_la", la_low - la0, 32'd1);
    chk("target_latched_lt", lt_low - lt0, 32'd0);

    // Async reset in the middle of a cycle during editing
    target = 1'b0;
    set_cur(17, 42);
    press(3'b001);
    lt0 = lt_low; la0 = la_low;
    @(posedge clk);
    #3 reset_i = 1'b1;
    #1;
    chk("async_reset", {13'd0, dig, load_time_n, load_alarm_n, editing, field},
        {13'd0, 14'd0, 5'b11000});
    #1 reset_i = 1'b0;
    repeat (3) tick();
    chk("async_reset_nostrobe", (lt_low - lt0) + (la_low - la0), 32'd0);

    // Timeout after TIMEOUT cycles without accepted edges
    set_cur(8, 0);
    target = 1'b0;
    lt0 = lt_low; la0 = la_low;
    enter_and_find();
    repeat (TIMEOUT - 1) tick();
    chk("timeout_before", 32'(editing), 32'd1);
    tick();
    chk("timeout_after", 32'(editing), 32'd0);
    chk("timeout_nostrobe", (lt_low - lt0) + (la_low - la0), 32'd0);
    chk("timeout_keeps_regs", {18'd0, dig}, {18'd0, hm(8, 0)});
    repeat (SETTLE + DBX) tick();

    // Press landing in the last cycle before timeout keeps editing
    enter_and_find();
    repeat (TIMEOUT - 2 - DBX) tick();
    inc_btn = 1'b1;
    repeat (HOLD) tick();
    inc_btn = 1'b0;
    repeat (SETTLE) tick();
    chk("late_press_editing", 32'(editing), 32'd1);
    chk("late_press_digits", {18'd0, dig}, {18'd0, hm(9, 0)});

    // Conflicting edges
    apply_reset();
    set_cur(10, 20);
    press(3'b001);
    press(3'b110);
    chk("incdec_hr", {18'd0, dig}, {18'd0, hm(10, 20)});
    press(3'b011);
    chk("setinc_field", 32'(field), 32'd2);
    chk("setinc_hr", {18'd0, dig}, {18'd0, hm(10, 20)});
    press(3'b110);
    chk("incdec_min", {18'd0, dig}, {18'd0, hm(10, 20)});
`ifdef DEBOUNCE_EN
    inc_btn = 1'b1;
    repeat (3) tick();
    inc_btn = 1'b0;
    repeat (SETTLE) tick();
    chk("glitch_ignored", {18'd0, dig}, {18'd0, hm(10, 20)});
`endif

    chk("strobes_never_both_low", both_low, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
